// File: rtl/uart_sys_ctrl.sv
// ============================================================================
// uart_sys_ctrl : UART command decoder driving the register file (write/read
//                 frames) and returning read bytes to the UART transmitter.
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    input  logic [DATA_WIDTH-1:0] RF_RdData,
    input  logic                  RF_RdData_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic [7:0]            ERR_CNT
);

    localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] CMD_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] RD_FAIL  = DATA_WIDTH'(8'hFF);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_ADDR = 3'd1;
    localparam logic [2:0] S_WR_DATA = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_TX_REQ  = 3'd5;
    localparam logic [2:0] S_TX_WAIT = 3'd6;

    logic [2:0]       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             err_evt;

    // All error sources in one cycle collapse into a single increment.
    always_comb begin
        err_evt = 1'b0;
        case (state)
            S_IDLE:    err_evt = RX_D_VLD && (RX_P_DATA != CMD_WR) && (RX_P_DATA != CMD_RD);
            S_RD_WAIT: err_evt = RX_D_VLD || (!RF_RdData_VLD && (tmo_cnt == CNT_LAST));
            S_TX_REQ,
            S_TX_WAIT: err_evt = RX_D_VLD;
            default:   err_evt = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= S_IDLE;
            RF_Address <= '0;
            RF_WrData  <= '0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            ERR_CNT    <= 8'd0;
            tmo_cnt    <= '0;
        end else begin
            RF_WrEn  <= 1'b0;
            RF_RdEn  <= 1'b0;
            TX_D_VLD <= 1'b0;

            if (err_evt && (ERR_CNT != 8'hFF)) begin
                ERR_CNT <= ERR_CNT + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == CMD_WR) begin
                            state <= S_WR_ADDR;
                        end else if (RX_P_DATA == CMD_RD) begin
                            state <= S_RD_ADDR;
                        end
                    end
                end
                S_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state      <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WrData <= RX_P_DATA;
                        RF_WrEn   <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        RF_RdEn    <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // Valid data on the terminal-count cycle takes priority.
                    if (RF_RdData_VLD) begin
                        TX_P_DATA <= RF_RdData;
                        state     <= S_TX_REQ;
                    end else if (tmo_cnt == CNT_LAST) begin
                        TX_P_DATA <= RD_FAIL;
                        state     <= S_TX_REQ;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_TX_REQ: begin
                    if (!TX_BUSY) begin
                        TX_D_VLD <= 1'b1;
                        state    <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    if (TX_BUSY) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_sys_ctrl.sv
// ============================================================================
// tb_uart_sys_ctrl : directed self-checking bench for uart_sys_ctrl.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_sys_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0;
    logic [3:0] RF_Address;
    logic       RF_WrEn;
    logic       RF_RdEn;
    logic [7:0] RF_WrData;
    logic [7:0] RF_RdData = 8'h00;
    logic       RF_RdData_VLD = 1'b0;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_BUSY = 1'b0;
    logic [7:0] ERR_CNT;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int tx_pulses = 0;
    int overlap   = 0;
    bit rf_respond = 1'b0;
    logic [1:0] rd_pipe = 2'b00;

    uart_sys_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .RD_TIMEOUT(16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .RF_Address   (RF_Address),
        .RF_WrEn      (RF_WrEn),
        .RF_RdEn      (RF_RdEn),
        .RF_WrData    (RF_WrData),
        .RF_RdData    (RF_RdData),
        .RF_RdData_VLD(RF_RdData_VLD),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .TX_BUSY      (TX_BUSY),
        .ERR_CNT      (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    // Strobe counters see the value held during the cycle that just ended.
    always @(posedge CLK) begin
        if (RF_WrEn) wr_pulses++;
        if (RF_RdEn) rd_pulses++;
        if (TX_D_VLD) tx_pulses++;
        if (RF_WrEn && RF_RdEn) overlap++;
    end

    // Register file answers two cycles after its read strobe.
    always @(negedge CLK) begin
        rd_pipe = {rd_pipe[0], RF_RdEn & rf_respond};
        RF_RdData_VLD = rd_pipe[1];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        @(negedge CLK);
        wr_pulses = 0;
        rd_pulses = 0;
        tx_pulses = 0;
    endtask

    // Pulse one byte; returns at the negedge of the cycle after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_tx(input int limit, output int lat);
        lat = 0;
        while (!TX_D_VLD && lat < limit) begin
            @(negedge CLK);
            lat++;
        end
        if (!TX_D_VLD) check("tx_vld_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_tx();
        @(negedge CLK);
        TX_BUSY = 1'b1;
        @(negedge CLK);
        TX_BUSY = 1'b0;
    endtask

    int lat;

    initial begin
        // Reset state
        idle(3);
        check("rst_wren",  {31'd0, RF_WrEn}, 32'd0);
        check("rst_rden",  {31'd0, RF_RdEn}, 32'd0);
        check("rst_txvld", {31'd0, TX_D_VLD}, 32'd0);
        check("rst_addr",  {28'd0, RF_Address}, 32'd0);
        check("rst_wdata", {24'd0, RF_WrData}, 32'd0);
        check("rst_txdata", {24'd0, TX_P_DATA}, 32'd0);
        check("rst_errcnt", {24'd0, ERR_CNT}, 32'd0);
        RST = 1'b1;

        // Write frame with idle gaps between bytes
        clear_counts();
        idle(8);
        send_byte(8'hAA);
        idle(8);
        send_byte(8'h05);
        idle(8);
        send_byte(8'h3C);
        check("wr_en",    {31'd0, RF_WrEn}, 32'd1);
        check("wr_addr",  {28'd0, RF_Address}, 32'd5);
        check("wr_data",  {24'd0, RF_WrData}, 32'h3C);
        idle(1);
        check("wr_en_off", {31'd0, RF_WrEn}, 32'd0);
        idle(2);
        check("wr_pulses", wr_pulses, 1);
        check("wr_no_rd",  rd_pulses, 0);
        check("wr_no_tx",  tx_pulses, 0);

        // Read frame, address upper bits truncated
        clear_counts();
        RF_RdData = 8'h7E;
        rf_respond = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h13);
        check("rd_en",   {31'd0, RF_RdEn}, 32'd1);
        check("rd_addr", {28'd0, RF_Address}, 32'd3);
        wait_tx(40, lat);
        check("rd_txdata", {24'd0, TX_P_DATA}, 32'h7E);
        finish_tx();
        idle(3);
        check("rd_pulses", rd_pulses, 1);
        check("rd_tx_pulses", tx_pulses, 1);
        check("rd_no_wr", wr_pulses, 0);
        check("rd_errcnt", {24'd0, ERR_CNT}, 32'd0);

        // TX backpressure
        clear_counts();
        RF_RdData = 8'h5A;
        TX_BUSY = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h01);
        idle(50);
        check("bp_no_tx", tx_pulses, 0);
        check("bp_txdata_held", {24'd0, TX_P_DATA}, 32'h5A);
        TX_BUSY = 1'b0;
        @(negedge CLK);
        check("bp_tx_vld", {31'd0, TX_D_VLD}, 32'd1);
        check("bp_txdata", {24'd0, TX_P_DATA}, 32'h5A);
        finish_tx();
        idle(3);
        check("bp_tx_pulses", tx_pulses, 1);

        // Read timeout
        clear_counts();
        rf_respond = 1'b0;
        RF_RdData = 8'h33;
        send_byte(8'hBB);
        send_byte(8'h02);
        wait_tx(80, lat);
        check("to_latency_min", {31'd0, (lat >= 16)}, 32'd1);
        check("to_txdata", {24'd0, TX_P_DATA}, 32'hFF);
        check("to_errcnt", {24'd0, ERR_CNT}, 32'd1);
        finish_tx();
        idle(3);
        check("to_tx_pulses", tx_pulses, 1);

        // Bad first byte, then a byte during TX_WAIT
        send_byte(8'h11);
        check("err_bad_first", {24'd0, ERR_CNT}, 32'd2);
        rf_respond = 1'b1;
        RF_RdData = 8'h44;
        send_byte(8'hBB);
        send_byte(8'h06);
        wait_tx(40, lat);
        send_byte(8'h55);
        check("err_tx_wait", {24'd0, ERR_CNT}, 32'd3);
        finish_tx();
        idle(2);

        // Saturation
        for (int i = 0; i < 100; i++) send_byte(8'h11);
        check("err_103", {24'd0, ERR_CNT}, 32'd103);
        for (int i = 0; i < 200; i++) send_byte(8'h11);
        check("err_sat", {24'd0, ERR_CNT}, 32'd255);

        // Reset mid-frame
        clear_counts();
        send_byte(8'hAA);
        send_byte(8'h04);
        @(negedge CLK);
        RST = 1'b0;
        RX_P_DATA = 8'h99;
        RX_D_VLD = 1'b1;
        @(negedge CLK);
        RX_D_VLD = 1'b0;
        @(negedge CLK);
        check("mrst_addr",  {28'd0, RF_Address}, 32'd0);
        check("mrst_wdata", {24'd0, RF_WrData}, 32'd0);
        check("mrst_txdata", {24'd0, TX_P_DATA}, 32'd0);
        check("mrst_errcnt", {24'd0, ERR_CNT}, 32'd0);
        RST = 1'b1;
        idle(2);
        check("mrst_no_wr", wr_pulses, 0);
        send_byte(8'hAA);
        send_byte(8'h09);
        send_byte(8'hC3);
        check("post_wr_en",   {31'd0, RF_WrEn}, 32'd1);
        check("post_wr_addr", {28'd0, RF_Address}, 32'd9);
        check("post_wr_data", {24'd0, RF_WrData}, 32'hC3);
        idle(2);
        check("post_wr_pulses", wr_pulses, 1);
        check("post_errcnt", {24'd0, ERR_CNT}, 32'd0);
        check("no_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
